// File: rtl/cordic_iter_ctrl_if.sv
// Operand/result handshake bundle for the iterative CORDIC controller.
// The slave side is the controller; the master side feeds operands and drains results.
interface cordic_iter_ctrl_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic signed [15:0] z_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] x_out;
  logic signed [17:0] y_out;
  logic signed [17:0] z_out;
  logic [3:0]         iter_idx;

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, iter_idx
  );

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, iter_idx
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Rotation-mode CORDIC sequencer: one micro-rotation per clock, NITER steps per operand,
// result held until the downstream consumer takes it. No gain compensation.
module cordic_iter_ctrl #(
  parameter int NITER = 16
) (
  input  logic              clk,
  input  logic              rst,
  cordic_iter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NITER - 1);

  state_t             state_q;
  logic signed [17:0] x_q, y_q, z_q;
  logic signed [17:0] x_d, y_d, z_d;
  logic [3:0]         idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic signed [17:0] atan_val;
  logic signed [17:0] x_sh, y_sh;

  // atan(2^-i) with pi mapped to 2^17
  always_comb begin
    atan_val = 18'sd0;
    case (idx_q)
      4'd0:  atan_val = 18'sd32768;
      4'd1:  atan_val = 18'sd19344;
      4'd2:  atan_val = 18'sd10221;
      4'd3:  atan_val = 18'sd5188;
      4'd4:  atan_val = 18'sd2604;
      4'd5:  atan_val = 18'sd1303;
      4'd6:  atan_val = 18'sd652;
      4'd7:  atan_val = 18'sd326;
      4'd8:  atan_val = 18'sd163;
      4'd9:  atan_val = 18'sd81;
      4'd10: atan_val = 18'sd41;
      4'd11: atan_val = 18'sd20;
      4'd12: atan_val = 18'sd10;
      4'd13: atan_val = 18'sd5;
      4'd14: atan_val = 18'sd3;
      4'd15: atan_val = 18'sd1;
      default: atan_val = 18'sd0;
    endcase
  end

  assign x_sh = x_q >>> idx_q;
  assign y_sh = y_q >>> idx_q;

  // Z sign picks the rotation direction; zero rotates positively
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (z_q[17]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_val;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            x_q        <= {bus.x_in, 2'b00};
            y_q        <= {bus.y_in, 2'b00};
            z_q        <= {bus.z_in, 2'b00};
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ITER;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ITER: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          idx_q <= idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.z_out     = z_q;
  assign bus.iter_idx  = idx_q;

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 SHALL have parameter NITER, default 16, number of CORDIC iterations per operand (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand triple presented.
REQ-005 SHALL have port in_ready  output  1  controller accepts operands this cycle.
REQ-006 SHALL have ports x_in, y_in, z_in  input  16 each  signed two's-complement operands; z_in scale 2^15 = pi rad.
REQ-007 SHALL have port out_valid  output  1  result held on x_out/y_out/z_out.
REQ-008 SHALL have port out_ready  input  1  downstream consumes result.
REQ-009 SHALL have ports x_out, y_out, z_out  output  18 each  signed results; Z scale 2^17 = pi rad.
REQ-010 SHALL have port iter_idx  output  4  current iteration index i, for debug and probing.

Function
REQ-011 SHALL implement FSM states IDLE, ITER, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept occurs on in_valid & in_ready.
REQ-013 On accept, SHALL load X={x_in,2'b00}, Y={y_in,2'b00}, Z={z_in,2'b00}, clear iter_idx to 0, go to ITER.
REQ-014 In ITER, each cycle SHALL do one rotation-mode step with d=+1 if Z[17]==0, else d=-1 (Z=0 counts as positive).
REQ-015 Step update SHALL be X<=X-d*(Y>>>i), Y<=Y+d*(X>>>i), Z<=Z-d*ATAN[i], all computed from pre-update values, arithmetic right shift, 18-bit wrap-around, no saturation.
REQ-016 ATAN[i] SHALL be an 18-bit constant ROM, round(atan(2^-i)*2^17/pi), i=0..15; ATAN[0]=32768, ATAN[1]=19344, ATAN[2]=10221.
REQ-017 iter_idx SHALL increment after each step; after the step with i=NITER-1, SHALL go to DONE.
REQ-018 In DONE, out_valid SHALL be 1 and x_out/y_out/z_out SHALL equal X/Y/Z, held stable until out_ready.
REQ-019 DONE with out_ready=1 SHALL return to IDLE next cycle; no accept in the same cycle, since in_ready=0 in DONE.
REQ-020 Latency SHALL be fixed: accept at edge k gives out_valid=1 from edge k+NITER; throughput SHALL be one operand per NITER+2 cycles with out_ready held high.
REQ-021 in_valid in ITER or DONE SHALL be ignored, with no state change and no operand capture.
REQ-022 No gain compensation (K~1.6468) SHALL be applied; downstream logic handles it.
REQ-023 out_valid SHALL be 0 in IDLE and ITER; x_out/y_out/z_out SHALL show register contents at all times.

Reset
REQ-024 rst=1 SHALL, asynchronously, force state IDLE, X=Y=Z=0, iter_idx=0, out_valid=0, in_ready=0 while rst asserted.
REQ-025 in_ready SHALL rise the first clk edge after rst deasserts.
REQ-026 rst during ITER or DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.

Verification
REQ-027 x_in=0x4000, y_in=0, z_in=0, NITER=16 -> out_valid exactly 16 cycles after accept; x_out=107925+/-4, y_out=0+/-4, |z_out|<=4.
REQ-028 x_in=0x4000, y_in=0, z_in=0x2000 (pi/4) -> x_out=y_out=76314+/-6, |z_out|<=4.
REQ-029 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE, then next operand accepted.
REQ-030 rst pulsed at iter_idx=7 -> all outputs 0 immediately; after release, a fresh operand completes with correct result and full latency.
REQ-031 z_in=0x0000 vs z_in=0xFFFF -> first step uses d=+1 vs d=-1 (Z after step 0 = -32768 vs -4+32768).
REQ-032 NITER=1 -> out_valid 1 cycle after accept; x_out={x_in,00}-{y_in,00}, y_out={y_in,00}+{x_in,00} for z_in>=0.
